// File: rtl/fetch_decode.sv
// fetch_decode -- instruction fetch and decode stage in front of the CPU execute block.
//
// Holds the program counter and reads one 32-bit word per instruction from a
// synchronous ROM (data returns one cycle after the read strobe). It splits the
// word into opcode/destination/source_1/source_2 and presents it to the CPU with a
// valid/ready handshake. It also handles CPU redirects, HLT/resume and reserved opcodes.
//
// Optional feature: define FETCH_DECODE_INSTR_COUNT_EN to add a 32-bit count
// of completed handshakes on port instr_count.
//
// Ports:
//   clk              clock, all state changes on posedge
//   rst              asynchronous active-low reset
//   imem_addr        ROM address (always the current pc)
//   imem_rd_en       ROM read strobe
//   imem_rdata       ROM data, valid one cycle after imem_rd_en
//   opcode/destination/source_1/source_2  decoded fields of the presented word
//   is_alu_flag      presented opcode is in 1..19
//   instr_pc         pc of the presented instruction
//   instr_valid      decoded instruction is presented
//   instr_ready      CPU accepts the instruction
//   redirect_valid   CPU requests a pc change (taken J/BEQ)
//   redirect_target  new pc for a redirect
//   resume           leave HALT
//   halted           FSM is in HALT
//   illegal_op       one-cycle pulse after a reserved opcode was fetched
//   instr_count      (optional) number of accepted instructions
module fetch_decode #(
  parameter int                  PC_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd_en,
  input  logic [31:0]         imem_rdata,
  output logic [4:0]          opcode,
  output logic [8:0]          destination,
  output logic [8:0]          source_1,
  output logic [8:0]          source_2,
  output logic                is_alu_flag,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                resume,
  output logic                halted,
`ifdef FETCH_DECODE_INSTR_COUNT_EN
  output logic [31:0]         instr_count,
`endif
  output logic                illegal_op
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
  localparam logic [4:0]          OP_HLT = 5'd25;

  typedef enum logic [1:0] {FETCH, CAPTURE, ISSUE, HALT} state_t;

  state_t              state_reg,    state_next;
  logic [PC_WIDTH-1:0] pc_reg,       pc_next;
  logic [31:0]         word_reg,     word_next;
  logic                alu_reg,      alu_next;
  logic [PC_WIDTH-1:0] instr_pc_reg, instr_pc_next;
  logic                valid_reg,    valid_next;
  logic                illegal_reg,  illegal_next;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
  logic [31:0]         count_reg,    count_next;
`endif

  logic [4:0] rd_opcode;
  assign rd_opcode = imem_rdata[31:27];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      word_reg     <= '0;
      alu_reg      <= 1'b0;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
      count_reg    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      word_reg     <= word_next;
      alu_reg      <= alu_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
      illegal_reg  <= illegal_next;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
      count_reg    <= count_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    word_next     = word_reg;
    alu_next      = alu_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    illegal_next  = 1'b0;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
    count_next    = count_reg;
`endif

    case (state_reg)
      FETCH: state_next = CAPTURE;

      CAPTURE: begin
        if (rd_opcode >= 5'd1 && rd_opcode <= 5'd24) begin
          word_next     = imem_rdata;
          alu_next      = (rd_opcode <= 5'd19);
          instr_pc_next = pc_reg;
          valid_next    = 1'b1;
          state_next    = ISSUE;
        end else if (rd_opcode == OP_HLT) begin
          // pc stays on the HLT word; resume steps past it
          state_next = HALT;
        end else begin
          illegal_next = 1'b1;
          pc_next      = pc_reg + PC_ONE;
          state_next   = FETCH;
        end
      end

      ISSUE: begin
        if (valid_reg && instr_ready) begin
          pc_next    = pc_reg + PC_ONE;
          valid_next = 1'b0;
          state_next = FETCH;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
          // Counted even when a redirect lands on the same cycle: the
          // handshake still completes.
          count_next = count_reg + 32'd1;
`endif
        end
      end

      HALT: begin
        if (resume) begin
          pc_next    = pc_reg + PC_ONE;
          state_next = FETCH;
        end
      end

      default: state_next = FETCH;
    endcase

    // Redirect overrides every transition outside HALT. Whatever word was in
    // flight or held is dropped without side effects.
    if (redirect_valid && state_reg != HALT) begin
      pc_next       = redirect_target;
      valid_next    = 1'b0;
      illegal_next  = 1'b0;
      word_next     = word_reg;
      alu_next      = alu_reg;
      instr_pc_next = instr_pc_reg;
      state_next    = FETCH;
    end
  end

  assign imem_addr   = pc_reg;
  // Gated with rst so the strobe stays low while reset is held.
  assign imem_rd_en  = (state_reg == FETCH) && rst;
  assign opcode      = word_reg[31:27];
  assign destination = word_reg[26:18];
  assign source_1    = word_reg[17:9];
  assign source_2    = word_reg[8:0];
  assign is_alu_flag = alu_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == HALT);
  assign illegal_op  = illegal_reg;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
  assign instr_count = count_reg;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: behavioural ROM with a one-cycle read,
// linear stimulus, and hand-computed expectations checked at each step.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [4:0]  opcode;
  logic [8:0]  destination, source_1, source_2;
  logic        is_alu_flag;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [8:0]  redirect_target;
  logic        resume;
  logic        halted;
  logic        illegal_op;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] rom [0:511];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_rd_en) imem_rdata <= rom[imem_addr];

  fetch_decode #(.PC_WIDTH(9), .RESET_PC(9'd0)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .opcode(opcode), .destination(destination), .source_1(source_1), .source_2(source_2),
    .is_alu_flag(is_alu_flag), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .resume(resume), .halted(halted),
`ifdef FETCH_DECODE_INSTR_COUNT_EN
    .instr_count(instr_count),
`endif
    .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_count(input string tag, input logic [31:0] exp);
`ifdef FETCH_DECODE_INSTR_COUNT_EN
    chk(tag, instr_count, exp);
`else
    // counter absent in this build
    if (tag.len() < 0) $display("%s %0h", tag, exp);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 32'h0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then releases it
  // just after an edge; the caller resumes in cycle 0 (state FETCH).
  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    resume = 1'b0;
    #1;
    chk("rst_rd_en",   imem_rd_en,  0);
    chk("rst_addr",    imem_addr,   0);
    chk("rst_valid",   instr_valid, 0);
    chk("rst_halted",  halted,      0);
    chk("rst_illegal", illegal_op,  0);
    chk("rst_opcode",  opcode,      0);
    chk("rst_ipc",     instr_pc,    0);
    chk_count("rst_count", 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 9'd0;
    resume = 1'b0;
    #2;

    // ---- basic decode, stall, redirect-with-handshake ----
    clear_rom();
    rom[0]     = 32'h3084_0A03;  // op 6, dst 0x021, s1 0x005, s2 0x003
    rom[1]     = 32'h1000_0007;  // op 2, s2 7
    rom[2]     = 32'hB800_0011;  // op 23
    rom[9'h40] = 32'h0800_0001;  // op 1
    do_reset();
    instr_ready = 1'b1;
    chk("c0_rd_en", imem_rd_en, 1);
    chk("c0_addr",  imem_addr,  0);
    chk("c0_valid", instr_valid, 0);
    step();
    chk("c1_rd_en", imem_rd_en, 0);
    chk("c1_valid", instr_valid, 0);
    step();
    chk("c2_valid", instr_valid, 1);
    chk("c2_opcode", opcode, 6);
    chk("c2_dst", destination, 9'h021);
    chk("c2_s1", source_1, 9'h005);
    chk("c2_s2", source_2, 9'h003);
    chk("c2_alu", is_alu_flag, 1);
    chk("c2_ipc", instr_pc, 0);
    step();
    chk("c3_rd_en", imem_rd_en, 1);
    chk("c3_addr", imem_addr, 1);
    chk("c3_valid", instr_valid, 0);
    chk_count("c3_count", 1);
    instr_ready = 1'b0;
    step();
    step();
    chk("stall_valid0", instr_valid, 1);
    chk("stall_ipc0", instr_pc, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_opcode", opcode, 2);
      chk("stall_s2", source_2, 7);
      chk("stall_ipc", instr_pc, 1);
      chk("stall_rd_en", imem_rd_en, 0);
    end
    instr_ready = 1'b1;
    step();
    chk("unstall_rd_en", imem_rd_en, 1);
    chk("unstall_addr", imem_addr, 2);
    chk("unstall_valid", instr_valid, 0);
    chk_count("unstall_count", 2);
    step();
    step();
    chk("op23_valid", instr_valid, 1);
    chk("op23_opcode", opcode, 23);
    chk("op23_alu", is_alu_flag, 0);
    redirect_valid = 1'b1;
    redirect_target = 9'h040;
    step();
    redirect_valid = 1'b0;
    chk("redir_addr", imem_addr, 9'h040);
    chk("redir_rd_en", imem_rd_en, 1);
    chk("redir_valid", instr_valid, 0);
    chk_count("redir_count", 3);
    instr_ready = 1'b0;
    step();
    step();
    chk("tgt_valid", instr_valid, 1);
    chk("tgt_ipc", instr_pc, 9'h040);
    chk("tgt_opcode", opcode, 1);

    // ---- HLT / resume (reset taken while an instruction is held) ----
    clear_rom();
    rom[0] = 32'h0800_0000;  // op 1
    rom[1] = 32'hC800_0000;  // op 25 HLT
    rom[2] = 32'h9800_0007;  // op 19, last ALU opcode
    do_reset();
    instr_ready = 1'b1;
    step();
    step();
    chk("h_op1_alu", is_alu_flag, 1);
    step();
    chk("h_fetch1", imem_addr, 1);
    step();
    step();
    chk("h_halted", halted, 1);
    chk("h_valid", instr_valid, 0);
    chk("h_rd_en", imem_rd_en, 0);
    chk_count("h_count", 1);
    redirect_valid = 1'b1;
    redirect_target = 9'h055;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_halted", halted, 1);
      chk("hold_valid", instr_valid, 0);
      chk("hold_rd_en", imem_rd_en, 0);
      chk("hold_addr", imem_addr, 1);
    end
    redirect_valid = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("res_halted", halted, 0);
    chk("res_rd_en", imem_rd_en, 1);
    chk("res_addr", imem_addr, 2);
    step();
    step();
    chk("op19_valid", instr_valid, 1);
    chk("op19_alu", is_alu_flag, 1);
    chk("op19_ipc", instr_pc, 2);
    step();
    chk_count("op19_count", 2);

    // ---- reserved opcodes ----
    clear_rom();
    rom[0] = 32'h0000_0000;  // op 0
    rom[1] = 32'hF800_0000;  // op 31
    rom[2] = 32'hC000_0000;  // op 24, legal non-ALU
    do_reset();
    instr_ready = 1'b1;
    step();
    chk("il_c1", illegal_op, 0);
    step();
    chk("il_c2_pulse", illegal_op, 1);
    chk("il_c2_valid", instr_valid, 0);
    chk("il_c2_addr", imem_addr, 1);
    chk("il_c2_rd_en", imem_rd_en, 1);
    step();
    chk("il_c3", illegal_op, 0);
    step();
    chk("il_c4_pulse", illegal_op, 1);
    chk("il_c4_addr", imem_addr, 2);
    step();
    chk("il_c5", illegal_op, 0);
    chk("il_c5_valid", instr_valid, 0);
    step();
    chk("op24_valid", instr_valid, 1);
    chk("op24_alu", is_alu_flag, 0);
    chk("op24_ipc", instr_pc, 2);
    chk_count("il_count", 0);

    // ---- redirect to last address, discarded read, pc wrap ----
    clear_rom();
    rom[0]     = 32'h0000_0000;  // reserved, must never be captured
    rom[9'h1FF] = 32'h2800_0000; // op 5
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 9'h1FF;
    step();
    redirect_valid = 1'b0;
    chk("w_addr", imem_addr, 9'h1FF);
    chk("w_rd_en", imem_rd_en, 1);
    chk("w_illegal1", illegal_op, 0);
    step();
    chk("w_illegal2", illegal_op, 0);
    step();
    chk("w_valid", instr_valid, 1);
    chk("w_ipc", instr_pc, 9'h1FF);
    chk("w_opcode", opcode, 5);
    chk("w_illegal3", illegal_op, 0);
    step();
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_rd_en", imem_rd_en, 1);
    chk_count("wrap_count", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
